// File: rtl/upower_fetch_unit.sv
// uPower instruction fetch front end: fetch PC, 1-cycle imem requests, instruction FIFO, redirect flush.
// Optional FETCH_PREDECODE_EN: early redirect on unconditional branches (opcode 18) as they are buffered.
module upower_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                       clock,
   input  logic                       reset,
   output logic                       imem_req,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic [31:0]                imem_rdata,
   input  logic                       redirect,
   input  logic [ADDR_W-1:0]          redirect_pc,
   output logic                       inst_valid,
   output logic [31:0]                inst,
   output logic [ADDR_W-1:0]          inst_pc,
   input  logic                       inst_ready,
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] req_pc;
   logic              inflight;
   logic              discard;
   logic [31:0]       mem_inst [DEPTH];
   logic [ADDR_W-1:0] mem_pc   [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   logic [CNT_W:0]    occupancy;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] next_pc;
   logic              next_discard;

   // Occupancy counts the in-flight word so the FIFO can never overflow; a same-cycle pop is not credited.
   assign occupancy  = {1'b0, count} + (CNT_W+1)'(inflight);
   assign imem_req   = !reset && (occupancy < (CNT_W+1)'(DEPTH));
   assign imem_addr  = fetch_pc;
   assign inst_valid = (count != '0);
   assign inst       = mem_inst[rd_ptr];
   assign inst_pc    = mem_pc[rd_ptr];
   assign fifo_count = count;
   assign push       = inflight && !discard && !redirect;
   assign pop        = inst_valid && inst_ready && !redirect;

   // Next fetch PC: sequential, then predecoded branch, then redirect (highest priority).
   always_comb begin
      next_pc      = fetch_pc;
      next_discard = 1'b0;
      if (imem_req) begin
         next_pc = fetch_pc + ADDR_W'(1);
      end
`ifdef FETCH_PREDECODE_EN
      if (push && (imem_rdata[31:26] == 6'd18)) begin
         next_pc      = ADDR_W'(imem_rdata[25:2]);
         next_discard = imem_req;
      end
`endif
      if (redirect) begin
         next_pc      = redirect_pc;
         next_discard = imem_req;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         inflight <= 1'b0;
         discard  <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_inst[i] <= '0;
            mem_pc[i]   <= '0;
         end
      end else begin
         fetch_pc <= next_pc;
         inflight <= imem_req;
         discard  <= next_discard;
         if (imem_req) begin
            req_pc <= fetch_pc;
         end
         if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               mem_inst[wr_ptr] <= imem_rdata;
               mem_pc[wr_ptr]   <= req_pc;
               wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_upower_fetch_unit.sv
// Directed self-checking bench for upower_fetch_unit (default and FETCH_PREDECODE_EN builds).
module tb_upower_fetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b1;
   logic [2:0]  fifo_count;

   logic        imem_req_b;
   logic [31:0] imem_addr_b;
   logic [31:0] imem_rdata_b = '0;
   logic        redirect_b = 1'b0;
   logic [31:0] redirect_pc_b = '0;
   logic        inst_valid_b;
   logic [31:0] inst_b;
   logic [31:0] inst_pc_b;
   logic        inst_ready_b = 1'b1;
   logic [2:0]  fifo_count_b;

   logic        predecode_mode = 1'b0;
   int          n_cmp = 0;
   int          n_fail = 0;

   upower_fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .inst_ready(inst_ready), .fifo_count(fifo_count)
   );

   upower_fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
      .clock(clock), .reset(reset), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
      .imem_rdata(imem_rdata_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
      .inst_valid(inst_valid_b), .inst(inst_b), .inst_pc(inst_pc_b),
      .inst_ready(inst_ready_b), .fifo_count(fifo_count_b)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (predecode_mode && a == 32'd5) return 32'h4800_0080;
      return a + 32'h100;
   endfunction

   // Instruction memories with a fixed one-cycle read latency.
   always @(posedge clock) begin
      if (imem_req) imem_rdata <= mem_word(imem_addr);
      if (imem_req_b) imem_rdata_b <= imem_addr_b + 32'h100;
   end

   task automatic next_cycle;
      @(posedge clock);
      #3;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      redirect = 1'b0;
      repeat (2) @(posedge clock);
      #2 reset = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #3;
      n_cmp++;
      if ({imem_req, inst_valid, fifo_count} !== 5'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_ctrl: got %b expected 00000", {imem_req, inst_valid, fifo_count});
      end
      n_cmp++;
      if ({inst, inst_pc} !== 64'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_data: got %h expected 0", {inst, inst_pc});
      end
      n_cmp++;
      if (imem_req_b !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_req_wrap: got %b expected 0", imem_req_b);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         n_fail++;
         $display("[TB] FAIL first_req: got %b/%h expected 1/0", imem_req, imem_addr);
      end
   endtask

   task automatic test_stream;
      logic [31:0] k;
      inst_ready = 1'b1;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c > 0) next_cycle();
         n_cmp++;
         if ({imem_req, imem_addr} !== {1'b1, 32'(c)}) begin
            n_fail++;
            $display("[TB] FAIL stream_addr c%0d: got %b/%h expected 1/%h", c, imem_req, imem_addr, c);
         end
         if (c < 2) begin
            n_cmp++;
            if (inst_valid !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL stream_early_valid c%0d: got %b expected 0", c, inst_valid);
            end
         end else begin
            k = 32'(c - 2);
            n_cmp++;
            if ({inst_valid, inst_pc, inst, fifo_count} !== {1'b1, k, k + 32'h100, 3'd1}) begin
               n_fail++;
               $display("[TB] FAIL stream_head c%0d: got %b/%h/%h/%0d expected 1/%h/%h/1",
                        c, inst_valid, inst_pc, inst, fifo_count, k, k + 32'h100);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] k;
      inst_ready = 1'b0;
      do_reset();
      repeat (9) next_cycle();
      n_cmp++;
      if ({fifo_count, imem_req, inst_valid, inst_pc} !== {3'd4, 1'b0, 1'b1, 32'h0}) begin
         n_fail++;
         $display("[TB] FAIL bp_saturate: got %0d/%b/%b/%h expected 4/0/1/0", fifo_count, imem_req, inst_valid, inst_pc);
      end
      inst_ready = 1'b1;
      for (int j = 0; j < 14; j++) begin
         if (j > 0) next_cycle();
         k = 32'(j);
         n_cmp++;
         if ({inst_valid, inst_pc, inst} !== {1'b1, k, k + 32'h100}) begin
            n_fail++;
            $display("[TB] FAIL bp_drain j%0d: got %b/%h/%h expected 1/%h/%h", j, inst_valid, inst_pc, inst, k, k + 32'h100);
         end
      end
   endtask

   task automatic test_redirect_full;
      inst_ready = 1'b0;
      do_reset();
      repeat (4) next_cycle();
      n_cmp++;
      if (fifo_count !== 3'd3) begin
         n_fail++;
         $display("[TB] FAIL redir_full_pre: got %0d expected 3", fifo_count);
      end
      redirect = 1'b1;
      redirect_pc = 32'h40;
      next_cycle();
      redirect = 1'b0;
      inst_ready = 1'b1;
      n_cmp++;
      if ({fifo_count, inst_valid, imem_req, imem_addr} !== {3'd0, 1'b0, 1'b1, 32'h40}) begin
         n_fail++;
         $display("[TB] FAIL redir_full_r1: got %0d/%b/%b/%h expected 0/0/1/40", fifo_count, inst_valid, imem_req, imem_addr);
      end
      next_cycle();
      n_cmp++;
      if (inst_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL redir_full_r2: got %b expected 0", inst_valid);
      end
      next_cycle();
      n_cmp++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h40, 32'h140}) begin
         n_fail++;
         $display("[TB] FAIL redir_full_r3: got %b/%h/%h expected 1/40/140", inst_valid, inst_pc, inst);
      end
   endtask

   task automatic test_redirect_stream;
      inst_ready = 1'b1;
      do_reset();
      repeat (5) next_cycle();
      n_cmp++;
      if (inst_pc !== 32'd3) begin
         n_fail++;
         $display("[TB] FAIL redir_stream_pre: got %h expected 3", inst_pc);
      end
      redirect = 1'b1;
      redirect_pc = 32'h80;
      next_cycle();
      redirect = 1'b0;
      n_cmp++;
      if ({fifo_count, inst_valid, imem_addr} !== {3'd0, 1'b0, 32'h80}) begin
         n_fail++;
         $display("[TB] FAIL redir_stream_r1: got %0d/%b/%h expected 0/0/80", fifo_count, inst_valid, imem_addr);
      end
      next_cycle();
      n_cmp++;
      if ({inst_valid, imem_addr} !== {1'b0, 32'h81}) begin
         n_fail++;
         $display("[TB] FAIL redir_stream_r2: got %b/%h expected 0/81", inst_valid, imem_addr);
      end
      next_cycle();
      n_cmp++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h80, 32'h180}) begin
         n_fail++;
         $display("[TB] FAIL redir_stream_r3: got %b/%h/%h expected 1/80/180", inst_valid, inst_pc, inst);
      end
      next_cycle();
      n_cmp++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h81, 32'h181}) begin
         n_fail++;
         $display("[TB] FAIL redir_stream_r4: got %b/%h/%h expected 1/81/181", inst_valid, inst_pc, inst);
      end
   endtask

   task automatic test_pc_wrap;
      do_reset();
      n_cmp++;
      if (imem_addr_b !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("[TB] FAIL wrap_addr0: got %h expected ffffffff", imem_addr_b);
      end
      next_cycle();
      n_cmp++;
      if (imem_addr_b !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL wrap_addr1: got %h expected 0", imem_addr_b);
      end
      next_cycle();
      n_cmp++;
      if ({inst_valid_b, inst_pc_b, inst_b} !== {1'b1, 32'hFFFF_FFFF, 32'hFF}) begin
         n_fail++;
         $display("[TB] FAIL wrap_head0: got %b/%h/%h expected 1/ffffffff/ff", inst_valid_b, inst_pc_b, inst_b);
      end
      next_cycle();
      n_cmp++;
      if ({inst_valid_b, inst_pc_b, inst_b} !== {1'b1, 32'h0, 32'h100}) begin
         n_fail++;
         $display("[TB] FAIL wrap_head1: got %b/%h/%h expected 1/0/100", inst_valid_b, inst_pc_b, inst_b);
      end
   endtask

   task automatic test_predecode;
      predecode_mode = 1'b1;
      inst_ready = 1'b1;
      do_reset();
      repeat (7) next_cycle();
      n_cmp++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 32'd5, 32'h4800_0080}) begin
         n_fail++;
         $display("[TB] FAIL pd_branch_head: got %b/%h/%h expected 1/5/48000080", inst_valid, inst_pc, inst);
      end
`ifdef FETCH_PREDECODE_EN
      n_cmp++;
      if (imem_addr !== 32'h20) begin
         n_fail++;
         $display("[TB] FAIL pd_target_addr: got %h expected 20", imem_addr);
      end
      next_cycle();
      n_cmp++;
      if (inst_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL pd_squash: got %b expected 0", inst_valid);
      end
      next_cycle();
      n_cmp++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h20, 32'h120}) begin
         n_fail++;
         $display("[TB] FAIL pd_target_head: got %b/%h/%h expected 1/20/120", inst_valid, inst_pc, inst);
      end
`else
      n_cmp++;
      if (imem_addr !== 32'd7) begin
         n_fail++;
         $display("[TB] FAIL pd_seq_addr: got %h expected 7", imem_addr);
      end
      next_cycle();
      n_cmp++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 32'd6, 32'h106}) begin
         n_fail++;
         $display("[TB] FAIL pd_seq_head6: got %b/%h/%h expected 1/6/106", inst_valid, inst_pc, inst);
      end
      next_cycle();
      n_cmp++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 32'd7, 32'h107}) begin
         n_fail++;
         $display("[TB] FAIL pd_seq_head7: got %b/%h/%h expected 1/7/107", inst_valid, inst_pc, inst);
      end
`endif
      predecode_mode = 1'b0;
   endtask

   task automatic test_reset_mid;
      inst_ready = 1'b0;
      do_reset();
      repeat (3) next_cycle();
      n_cmp++;
      if (fifo_count !== 3'd2) begin
         n_fail++;
         $display("[TB] FAIL rmid_pre: got %0d expected 2", fifo_count);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({imem_req, inst_valid, fifo_count, inst, inst_pc} !== 69'h0) begin
         n_fail++;
         $display("[TB] FAIL rmid_clear: got %b/%b/%0d/%h/%h expected all 0", imem_req, inst_valid, fifo_count, inst, inst_pc);
      end
      repeat (2) @(posedge clock);
      #2 reset = 1'b0;
      inst_ready = 1'b1;
      #1;
      n_cmp++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         n_fail++;
         $display("[TB] FAIL rmid_restart: got %b/%h expected 1/0", imem_req, imem_addr);
      end
      repeat (2) next_cycle();
      n_cmp++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0, 32'h100}) begin
         n_fail++;
         $display("[TB] FAIL rmid_first: got %b/%h/%h expected 1/0/100", inst_valid, inst_pc, inst);
      end
   endtask

   initial begin
      $display("[TB] starting upower_fetch_unit bench");
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_full();
      test_redirect_stream();
      test_pc_wrap();
      test_predecode();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
